// File: rtl/inst_loader.sv
// Assembles UART bytes (MSB first) into instruction words and writes them to
// consecutive instruction-memory addresses until HALT or the memory is full.
//   IDLE  | waiting for start, bytes ignored
//   LOAD  | collecting bytes of the current word
//   WRITE | one-cycle write strobe for the completed word
//   DONE  | load finished (halt or overflow), bytes ignored
module inst_loader #(
  parameter int                  N_BITS    = 8,
  parameter int                  NB_DATA   = 32,
  parameter int                  NB_ADDR   = 8,
  parameter logic [NB_DATA-1:0]  HALT_INST = 32'hFFFF_FFFF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_rx_done,
  input  logic [N_BITS-1:0]  i_rx_data,
  output logic [NB_DATA-1:0] o_inst_load,
  output logic [NB_ADDR-1:0] o_address,
  output logic               o_en_write,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
  output logic [1:0]         o_byte_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t             state, next_state;
  logic [NB_DATA-1:0] shift_word;
  logic [NB_ADDR-1:0] addr;
  logic               start_ok;
  logic               last_addr;
  logic               is_halt;
  logic               accept;

  assign start_ok  = i_start & ((state == IDLE) | (state == DONE));
  assign last_addr = (addr == {NB_ADDR{1'b1}});
  // o_inst_load holds the word being written while in WRITE
  assign is_halt   = (o_inst_load == HALT_INST);
  // a byte seen during WRITE only counts if loading continues afterwards
  assign accept    = i_rx_done & ((state == LOAD) | ((state == WRITE) & (next_state == LOAD)));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_start) next_state = LOAD;
      LOAD:    if (i_rx_done && (o_byte_cnt == 2'd3)) next_state = WRITE;
      WRITE:   next_state = (is_halt || last_addr) ? DONE : LOAD;
      DONE:    if (i_start) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state == LOAD) | (state == WRITE);
    o_en_write = (state == WRITE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      shift_word  <= '0;
      addr        <= '0;
      o_byte_cnt  <= 2'd0;
      o_done      <= 1'b0;
      o_overflow  <= 1'b0;
      o_inst_load <= '0;
      o_address   <= '0;
    end else if (start_ok) begin
      shift_word <= '0;
      addr       <= '0;
      o_byte_cnt <= 2'd0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (accept) begin
        shift_word <= {shift_word[NB_DATA-N_BITS-1:0], i_rx_data};
        o_byte_cnt <= o_byte_cnt + 2'd1;
        if ((state == LOAD) && (o_byte_cnt == 2'd3)) begin
          o_inst_load <= {shift_word[NB_DATA-N_BITS-1:0], i_rx_data};
          o_address   <= addr;
        end
      end
      if (state == WRITE) begin
        if (is_halt)        o_done     <= 1'b1;
        else if (last_addr) o_overflow <= 1'b1;
        else                addr       <= addr + NB_ADDR'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader against a transaction-level model of the
// byte stream, word grouping, address sequence and end-of-load rules.
module tb_inst_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] inst_load;
  logic [7:0]  address;
  logic        en_write, busy, done, overflow;
  logic [1:0]  byte_cnt;

  inst_loader dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_rx_done  (rx_done),
    .i_rx_data  (rx_data),
    .o_inst_load(inst_load),
    .o_address  (address),
    .o_en_write (en_write),
    .o_busy     (busy),
    .o_done     (done),
    .o_overflow (overflow),
    .o_byte_cnt (byte_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: load session, bytes of the pending word, next address
  bit        m_active = 0;
  int        m_cnt = 0;
  bit [7:0]  m_bytes [4];
  int        m_addr = 0;
  bit        m_done = 0;
  bit        m_ovf = 0;
  int        m_writes = 0;

  int        n_writes = 0;
  logic      prev_we = 1'b0;

  always @(negedge clk) begin
    if (en_write === 1'b1) begin
      n_writes++;
      check_eq("we_back2back", prev_we, 0);
    end
    prev_we = en_write;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit          wr;
    logic [31:0] w;
    int          a;
    wr = 0; w = '0; a = 0;
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    if (m_active) begin
      m_bytes[m_cnt] = b;
      m_cnt = (m_cnt + 1) % 4;
      if (m_cnt == 0) begin
        w  = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        a  = m_addr;
        wr = 1;
        m_writes++;
        if (w == HALT) begin
          m_done = 1; m_active = 0;
        end else if (m_addr == DEPTH - 1) begin
          m_ovf = 1; m_active = 0;
        end else begin
          m_addr++;
        end
      end
    end
    check_eq("en_write", en_write, wr);
    if (wr) begin
      check_eq("inst_load", inst_load, w);
      check_eq("address", address, a);
      check_eq("busy_in_write", busy, 1);
    end
    check_eq("byte_cnt", byte_cnt, m_cnt);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] sh;
      sh = w >> (8 * (3 - i));
      send_byte(sh[7:0]);
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask

  task automatic do_start(input bit with_byte, input logic [7:0] b);
    start   = 1'b1;
    rx_done = with_byte;
    rx_data = b;
    @(negedge clk);
    start   = 1'b0;
    rx_done = 1'b0;
    if (!m_active) begin
      m_active = 1; m_cnt = 0; m_addr = 0; m_done = 0; m_ovf = 0;
    end
    check_eq("start_byte_cnt", byte_cnt, m_cnt);
    check_eq("start_busy", busy, m_active);
    check_eq("start_done", done, m_done);
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_busy"}, busy, m_active);
    check_eq({tag, "_done"}, done, m_done);
    check_eq({tag, "_ovf"}, overflow, m_ovf);
    check_eq({tag, "_cnt"}, byte_cnt, m_cnt);
    check_eq({tag, "_writes"}, n_writes, m_writes);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_inst", inst_load, 0);
    check_eq("rst_addr", address, 0);
    check_eq("rst_we", en_write, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_cnt", byte_cnt, 0);
    m_active = 0; m_cnt = 0; m_addr = 0; m_done = 0; m_ovf = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    idle(1);
    check_status("reset");

    // first word, then start ignored mid-word, then halt
    do_start(0, 8'h00);
    send_word(32'h2001_0005, 1);
    idle(1);
    check_status("word0");
    send_byte(8'h12);
    send_byte(8'h34);
    do_start(0, 8'h00);
    send_byte(8'h56);
    send_byte(8'h78);
    idle(1);
    check_status("start_ignored");
    send_word(HALT, 1);
    idle(1);
    check_status("halt1");
    send_word($urandom, 1);
    idle(1);
    check_status("after_halt");

    // restart from DONE with a simultaneous byte; back-to-back words incl. 8'hAB in WRITE
    do_start(1, 8'h77);
    send_word($urandom, 0);
    send_word({8'hAB, 24'($urandom)}, 0);
    send_word(HALT, 0);
    idle(1);
    check_status("halt2");

    // reset in the middle of a word
    do_start(0, 8'h00);
    send_byte(8'h5A);
    send_byte(8'hA5);
    do_reset();
    idle(1);
    check_status("midreset");
    send_byte(8'h99);
    do_start(0, 8'h00);
    send_word(32'h1122_3344, 1);
    idle(1);
    check_status("after_reset");

    // fill the whole memory without HALT
    do_reset();
    do_start(0, 8'h00);
    for (int i = 0; i < DEPTH; i++)
      send_word({8'($urandom_range(0, 254)), 24'($urandom)}, 1);
    idle(1);
    check_status("overflow");
    send_word($urandom, 1);
    idle(1);
    check_status("after_overflow");

    // random loads ending in HALT, with occasional ignored starts mid-word
    for (int r = 0; r < 3; r++) begin
      do_start(0, 8'h00);
      for (int i = 0; i < 40 && m_active; i++) begin
        if ($urandom_range(0, 7) == 0) send_word(HALT, 1);
        else send_word({8'($urandom_range(0, 254)), 24'($urandom)}, 1);
        if (m_active && m_cnt != 0 && $urandom_range(0, 3) == 0) do_start(0, 8'h00);
      end
      if (m_active) send_word(HALT, 1);
      idle(1);
      check_status("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
